// File: rtl/wb_commit_trace_buffer.sv
// Commit trace buffer: captures retired WB-stage instructions into a small FIFO and
// replays them on a valid/ready debug-trace port. Optional counters under COMMIT_CNT_EN.
module wb_commit_trace_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_Valid,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_Instr,
  input  logic        WB_RFWr,
  input  logic [4:0]  WB_Dst,
  input  logic [31:0] WB_Result,
  input  logic        Trace_Ready,
  output logic        Trace_Valid,
  output logic [31:0] debug_wb_pc,
  output logic [31:0] debug_wb_instr,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
`ifdef COMMIT_CNT_EN
  output logic [31:0] Commit_Cnt,
  output logic [31:0] Stall_Cnt,
`endif
  output logic        Commit_Stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a record transfers on every rising edge where Trace_Valid && Trace_Ready;
  // Trace_Valid and the head fields stay stable until that transfer happens.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [3:0]  wen_mem   [DEPTH];
  logic [4:0]  wnum_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, push, pop, rec_we;

  assign full         = (count == CNT_W'(DEPTH));
  assign Trace_Valid  = (count != '0);
  assign pop          = Trace_Valid && Trace_Ready;
  assign push         = WB_Valid && (!full || pop);
  assign Commit_Stall = WB_Valid && full && !Trace_Ready;
  // Writes to $0 never change architectural state, so they are traced as no-writes.
  assign rec_we       = WB_RFWr && (WB_Dst != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= WB_PC;
      instr_mem[wr_ptr] <= WB_Instr;
      wen_mem[wr_ptr]   <= {4{rec_we}};
      wnum_mem[wr_ptr]  <= WB_Dst;
      wdata_mem[wr_ptr] <= rec_we ? WB_Result : 32'h0;
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  always_comb begin
    debug_wb_pc       = 32'h0;
    debug_wb_instr    = 32'h0;
    debug_wb_rf_wen   = 4'h0;
    debug_wb_rf_wnum  = 5'h0;
    debug_wb_rf_wdata = 32'h0;
    if (Trace_Valid) begin
      debug_wb_pc       = pc_mem[rd_ptr];
      debug_wb_instr    = instr_mem[rd_ptr];
      debug_wb_rf_wen   = wen_mem[rd_ptr];
      debug_wb_rf_wnum  = wnum_mem[rd_ptr];
      debug_wb_rf_wdata = wdata_mem[rd_ptr];
    end
  end

`ifdef COMMIT_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Commit_Cnt <= 32'h0;
      Stall_Cnt  <= 32'h0;
    end else begin
      if (pop)          Commit_Cnt <= Commit_Cnt + 32'd1;
      if (Commit_Stall) Stall_Cnt  <= Stall_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_commit_trace_buffer.sv
// Directed bench for wb_commit_trace_buffer: inputs change on the falling edge,
// outputs are checked before the next rising edge. Counter checks under COMMIT_CNT_EN.
module tb_wb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WB_Valid = 1'b0;
  logic [31:0] WB_PC = '0;
  logic [31:0] WB_Instr = '0;
  logic        WB_RFWr = 1'b0;
  logic [4:0]  WB_Dst = '0;
  logic [31:0] WB_Result = '0;
  logic        Trace_Ready = 1'b0;
  logic        Trace_Valid;
  logic [31:0] debug_wb_pc, debug_wb_instr, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic        Commit_Stall;
`ifdef COMMIT_CNT_EN
  logic [31:0] Commit_Cnt, Stall_Cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  wb_commit_trace_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .WB_Valid(WB_Valid), .WB_PC(WB_PC), .WB_Instr(WB_Instr),
    .WB_RFWr(WB_RFWr), .WB_Dst(WB_Dst), .WB_Result(WB_Result),
    .Trace_Ready(Trace_Ready), .Trace_Valid(Trace_Valid),
    .debug_wb_pc(debug_wb_pc), .debug_wb_instr(debug_wb_instr),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
`ifdef COMMIT_CNT_EN
    .Commit_Cnt(Commit_Cnt), .Stall_Cnt(Stall_Cnt),
`endif
    .Commit_Stall(Commit_Stall)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive_wb(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic rfwr, input logic [4:0] dst, input logic [31:0] res);
    WB_Valid  = v;
    WB_PC     = pc;
    WB_Instr  = instr;
    WB_RFWr   = rfwr;
    WB_Dst    = dst;
    WB_Result = res;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    Trace_Ready = 1'b0;
    drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'h0, Trace_Valid}, 32'h0);
    check({tag, "_pc"}, debug_wb_pc, 32'h0);
  endtask

  initial begin
    // reset state
    #1;
    check("rst_valid", {31'h0, Trace_Valid}, 32'h0);
    check("rst_stall", {31'h0, Commit_Stall}, 32'h0);
    check("rst_pc", debug_wb_pc, 32'h0);
    check("rst_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
`ifdef COMMIT_CNT_EN
    check("rst_commit_cnt", Commit_Cnt, 32'h0);
    check("rst_stall_cnt", Stall_Cnt, 32'h0);
`endif
    next_cycle();
    rst = 1'b1;

    // single push, one cycle latency, then drained
    Trace_Ready = 1'b1;
    drive_wb(1'b1, 32'hBFC00000, 32'h24051234, 1'b1, 5'd5, 32'h1234);
    check("s1_no_bypass", {31'h0, Trace_Valid}, 32'h0);
    next_cycle();
    drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("s1_valid", {31'h0, Trace_Valid}, 32'h1);
    check("s1_pc", debug_wb_pc, 32'hBFC00000);
    check("s1_instr", debug_wb_instr, 32'h24051234);
    check("s1_wen", {28'h0, debug_wb_rf_wen}, 32'hF);
    check("s1_wnum", {27'h0, debug_wb_rf_wnum}, 32'd5);
    check("s1_wdata", debug_wb_rf_wdata, 32'h1234);
    next_cycle();
    check_empty("s1_empty");

    // $0 write and RFWr=0 are both recorded as no-write
    drive_wb(1'b1, 32'h200, 32'h2400DEAD, 1'b1, 5'd0, 32'hDEAD);
    next_cycle();
    drive_wb(1'b1, 32'h204, 32'h00000055, 1'b0, 5'd7, 32'h55);
    check("s2_pc", debug_wb_pc, 32'h200);
    check("s2_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    check("s2_wnum", {27'h0, debug_wb_rf_wnum}, 32'd0);
    check("s2_wdata", debug_wb_rf_wdata, 32'h0);
    next_cycle();
    drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("s2b_pc", debug_wb_pc, 32'h204);
    check("s2b_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    check("s2b_wnum", {27'h0, debug_wb_rf_wnum}, 32'd7);
    check("s2b_wdata", debug_wb_rf_wdata, 32'h0);
    next_cycle();
    check_empty("s2_empty");

    // fill, stall on the 5th, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_wb(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 5'(i + 1), 32'h10 + 32'(i));
      exp_q.push_back(32'h100 + 32'(4 * i));
      check("s3_fill_stall", {31'h0, Commit_Stall}, 32'h0);
      next_cycle();
    end
    drive_wb(1'b1, 32'h110, 32'h1004, 1'b1, 5'd5, 32'h14);
    exp_q.push_back(32'h110);
    check("s3_stall", {31'h0, Commit_Stall}, 32'h1);
    check("s3_head", debug_wb_pc, 32'h100);
    next_cycle();
    check("s3_stall_hold", {31'h0, Commit_Stall}, 32'h1);
    check("s3_no_overwrite", debug_wb_pc, 32'h100);
    next_cycle();
    next_cycle();
    Trace_Ready = 1'b1;
    #1;
    check("s3_unstall", {31'h0, Commit_Stall}, 32'h0);
    check("s3_head_wnum", {27'h0, debug_wb_rf_wnum}, 32'd1);
    check("s3_head_wdata", debug_wb_rf_wdata, 32'h10);
    for (int i = 0; i < 5; i++) begin
      check("s3_order", debug_wb_pc, exp_q.pop_front());
      next_cycle();
      if (i == 0) drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef COMMIT_CNT_EN
      check("s3_commit_cnt_step", Commit_Cnt, 32'(i + 1));
`endif
    end
    check_empty("s3_empty");
`ifdef COMMIT_CNT_EN
    check("s3_commit_cnt", Commit_Cnt, 32'd5);
    check("s3_stall_cnt", Stall_Cnt, 32'd3);
`endif

    // full FIFO with simultaneous push and pop, across pointer wrap
    Trace_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wb(1'b1, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i), 1'b1, 5'd9, 32'h30 + 32'(i));
      exp_q.push_back(32'h300 + 32'(4 * i));
      next_cycle();
    end
    Trace_Ready = 1'b1;
    drive_wb(1'b1, 32'h310, 32'h3004, 1'b1, 5'd9, 32'h34);
    exp_q.push_back(32'h310);
    check("s4_pp_stall", {31'h0, Commit_Stall}, 32'h0);
    check("s4_pp_head", debug_wb_pc, exp_q.pop_front());
    next_cycle();
    drive_wb(1'b1, 32'h314, 32'h3005, 1'b1, 5'd9, 32'h35);
    exp_q.push_back(32'h314);
    check("s4_pp2_stall", {31'h0, Commit_Stall}, 32'h0);
    check("s4_pp2_head", debug_wb_pc, exp_q.pop_front());
    next_cycle();
    Trace_Ready = 1'b0;
    drive_wb(1'b1, 32'h318, 32'h3006, 1'b1, 5'd9, 32'h36);
    check("s4_still_full", {31'h0, Commit_Stall}, 32'h1);
    Trace_Ready = 1'b1;
    drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("s4_order", debug_wb_pc, exp_q.pop_front());
      next_cycle();
    end
    check_empty("s4_empty");

    // asynchronous reset with records buffered
    Trace_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_wb(1'b1, 32'h400 + 32'(4 * i), 32'h4000, 1'b1, 5'd2, 32'h40);
      next_cycle();
    end
    drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("s5_pre_valid", {31'h0, Trace_Valid}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check_empty("s5_async");
    check("s5_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    check("s5_wdata", debug_wb_rf_wdata, 32'h0);
    check("s5_stall", {31'h0, Commit_Stall}, 32'h0);
`ifdef COMMIT_CNT_EN
    check("s5_commit_cnt", Commit_Cnt, 32'h0);
    check("s5_stall_cnt", Stall_Cnt, 32'h0);
`endif
    next_cycle();
    rst = 1'b1;
    drive_wb(1'b1, 32'h500, 32'h5000, 1'b1, 5'd3, 32'h77);
    next_cycle();
    drive_wb(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("s5_first_pc", debug_wb_pc, 32'h500);
    check("s5_first_wnum", {27'h0, debug_wb_rf_wnum}, 32'd3);
    check("s5_first_wdata", debug_wb_rf_wdata, 32'h77);
    Trace_Ready = 1'b1;
    next_cycle();
    check_empty("s5_empty");

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
